// File: rtl/cdbus_frame_tx_if.sv
// Byte-stream handshake into the CDBUS frame transmitter.
// The producer drives data/last/valid; the transmitter answers with ready.
`timescale 1ns/1ps
interface cdbus_frame_tx_if;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_last, output in_valid, input in_ready);
    modport slave  (input in_data, input in_last, input in_valid, output in_ready);
endinterface

// File: rtl/cdbus_frame_tx.sv
// CDBUS frame transmitter: serialises a byte stream as 8N1 characters,
// drives the RS-485 enable with programmable pre/post guard times and,
// when CDBUS_TX_CRC_EN is defined, appends the CRC16 (poly 0xA001, init
// 0xFFFF) low byte first. Without the macro the payload must carry its CRC.
`timescale 1ns/1ps
module cdbus_frame_tx #(
    parameter int DIV_W   = 16,
    parameter int GUARD_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DIV_W-1:0]   div,
    input  logic [GUARD_W-1:0] pre_len,
    input  logic [GUARD_W-1:0] post_len,
    cdbus_frame_tx_if.slave    in_if,
    output logic               tx,
    output logic               tx_en,
    output logic               busy,
    output logic               underrun
);
    localparam int IDX_W = (GUARD_W > 4) ? GUARD_W : 4;

`ifdef CDBUS_TX_CRC_EN
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_START, S_DATA, S_STOP, S_CRC_LO, S_CRC_HI, S_POST} state_t;

    function automatic logic [15:0] crc16_upd(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    logic [15:0] crc_q, crc_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_START, S_DATA, S_STOP, S_POST} state_t;
`endif

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d, div_q, div_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GUARD_W-1:0] pre_q, pre_d, post_q, post_d;
    logic [7:0]         shift_q, shift_d, hold_data_q, hold_data_d;
    logic               last_sent_q, last_sent_d, hold_last_q, hold_last_d;
    logic               hold_full_q, hold_full_d, closed_q, closed_d;
    logic               underrun_q, underrun_d;
    logic               accept, tick, abort;

    assign in_if.in_ready = !hold_full_q && !closed_q;
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign tick           = (cnt_q == div_q);
    assign tx_en          = (state_q != S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign underrun       = underrun_q;

    // Next-state, bit timing, holding register and CRC update.
    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == S_IDLE || tick) ? '0 : cnt_q + DIV_W'(1);
        idx_d       = idx_q;
        div_d       = div_q;
        pre_d       = pre_q;
        post_d      = post_q;
        shift_d     = shift_q;
        last_sent_d = last_sent_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        closed_d    = closed_q;
        underrun_d  = 1'b0;
        abort       = 1'b0;
`ifdef CDBUS_TX_CRC_EN
        crc_d       = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    div_d   = div;
                    pre_d   = pre_len;
                    post_d  = post_len;
                    idx_d   = '0;
                    state_d = (pre_len == '0) ? S_START : S_PRE;
                end
            end
            S_PRE: begin
                if (tick) begin
                    if (idx_q + IDX_W'(1) == IDX_W'(pre_q)) begin
                        idx_d   = '0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_START: begin
                if (tick) begin
                    // The byte leaves the holding register as the start bit ends.
                    shift_d     = hold_data_q;
                    last_sent_d = hold_last_q;
                    hold_full_d = 1'b0;
`ifdef CDBUS_TX_CRC_EN
                    crc_d       = crc16_upd(crc_q, hold_data_q);
`endif
                    idx_d       = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == IDX_W'(7)) begin
                        idx_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    idx_d = '0;
                    if (last_sent_q) begin
`ifdef CDBUS_TX_CRC_EN
                        shift_d = crc_q[7:0];
                        state_d = S_CRC_LO;
`else
                        state_d = (post_q == '0) ? S_IDLE : S_POST;
`endif
                    end else if (hold_full_q) begin
                        state_d = S_START;
                    end else begin
                        // Producer fell behind: abort the frame without CRC.
                        underrun_d = 1'b1;
                        closed_d   = 1'b1;
                        abort      = 1'b1;
                        state_d    = (post_q == '0) ? S_IDLE : S_POST;
                    end
                end
            end
`ifdef CDBUS_TX_CRC_EN
            S_CRC_LO, S_CRC_HI: begin
                if (tick) begin
                    if (idx_q >= IDX_W'(1) && idx_q <= IDX_W'(8)) begin
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                    if (idx_q == IDX_W'(9)) begin
                        idx_d = '0;
                        if (state_q == S_CRC_LO) begin
                            shift_d = crc_q[15:8];
                            state_d = S_CRC_HI;
                        end else begin
                            state_d = (post_q == '0) ? S_IDLE : S_POST;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`endif
            S_POST: begin
                if (tick) begin
                    if (idx_q + IDX_W'(1) == IDX_W'(post_q)) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            hold_data_d = in_if.in_data;
            hold_last_d = in_if.in_last;
            hold_full_d = 1'b1;
            if (in_if.in_last) closed_d = 1'b1;
        end
        // A byte arriving in the very cycle of an abort belongs to the dead frame.
        if (abort) hold_full_d = 1'b0;
        if (state_d == S_IDLE && state_q != S_IDLE) begin
            closed_d = 1'b0;
`ifdef CDBUS_TX_CRC_EN
            crc_d    = 16'hFFFF;
`endif
        end
    end

    // Serial line: start bit low, data LSB first, everything else idle high.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[0];
`ifdef CDBUS_TX_CRC_EN
            S_CRC_LO, S_CRC_HI: begin
                if (idx_q == '0)             tx = 1'b0;
                else if (idx_q <= IDX_W'(8)) tx = shift_q[0];
            end
`endif
            default: tx = 1'b1;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            last_sent_q <= 1'b0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            closed_q    <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef CDBUS_TX_CRC_EN
            crc_q       <= 16'hFFFF;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            last_sent_q <= last_sent_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            closed_q    <= closed_d;
            underrun_q  <= underrun_d;
`ifdef CDBUS_TX_CRC_EN
            crc_q       <= crc_d;
`endif
        end
    end

    // Datapath registers: qualified by control state, so no reset needed.
    always_ff @(posedge clk) begin
        shift_q     <= shift_d;
        hold_data_q <= hold_data_d;
        div_q       <= div_d;
        pre_q       <= pre_d;
        post_q      <= post_d;
    end
endmodule

// File: doc/cdbus_frame_tx.md
Name: cdbus_frame_tx

Overview:
- Transmit-side counterpart of the CDBUS controller's receive path.
- Accepts a byte stream per frame over a valid/ready handshake and serialises it as UART-style characters: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Appends the CDBUS CRC16 and drives the RS-485 driver enable (tx_en) with programmable pre and post guard times.
- Used both as the controller's TX engine and as the bench stimulus source feeding the controller's rx line.

Parameters:
- DIV_W, 16, width of the baud divisor input.
- GUARD_W, 4, width of the pre_len and post_len inputs, in bit periods.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- div  in  DIV_W  bit period = div+1 clk cycles; sampled at frame start, held for the whole frame.
- pre_len  in  GUARD_W  bit periods tx_en is high before the first start bit; 0 = no guard.
- post_len  in  GUARD_W  bit periods tx_en stays high after the last stop bit; 0 = no guard.
- in_data  in  8  payload byte.
- in_last  in  1  marks in_data as the last payload byte of the frame.
- in_valid  in  1  byte offered.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- tx  out  1  serial line, idle high.
- tx_en  out  1  line driver enable.
- busy  out  1  high from first-byte accept until POST ends.
- underrun  out  1  one-cycle pulse on underrun (holding register empty mid-frame).

Behaviour:
- Reset values: tx=1, tx_en=0, busy=0, underrun=0, in_ready=1. Holding register empty, CRC=0xFFFF, state IDLE.
- Reset is asynchronous: asserting it mid-frame forces all of the above immediately; the partial frame is lost.
- Holding register: one byte plus its last flag.
  - in_ready = !hold_full && !closed.
  - closed sets on accepting a byte with in_last=1 and clears on return to IDLE.
- Loading the shift register empties the holding register in that cycle; same-cycle accept and load is allowed.
- States: IDLE, PRE, START, DATA, STOP, CRC_LO, CRC_HI, POST.
- IDLE:
  - On the first accept, latch div, pre_len and post_len.
  - Next cycle: tx_en=1, busy=1, go to PRE, or go directly to START if pre_len=0.
- PRE: tx=1 for pre_len*(div+1) clocks, then START.
- START: load the shift register from the holding register and update the CRC with that byte. tx=0 for one bit period.
- DATA: 8 bit periods, LSB first.
- STOP: tx=1 for one bit period. At the end of STOP:
  - Byte just sent was last: go to CRC_LO.
  - Else, holding register full: go to START.
  - Else: pulse underrun and go to POST with no CRC. The frame is aborted; closed is set until IDLE and further accepts are refused.
- CRC: poly 0xA001 (reflected 0x8005), init 0xFFFF, no final XOR. Bytewise update; the 8-iteration loop may be combinational.
- CRC_LO / CRC_HI: each is a full 10-bit character carrying the CRC low byte, then the CRC high byte. The CRC register is frozen while these are sent.
- POST: tx=1 for post_len*(div+1) clocks, then IDLE. On entering IDLE: tx_en=0, busy=0, CRC reset to 0xFFFF.
- Back-to-back frames: a byte offered in the IDLE cycle after POST is accepted; frames never overlap.
- div=0 is legal: 1 clk per bit.

Optional Feature:
- Macro CDBUS_TX_CRC_EN.
- Defined: CRC logic present; CRC_LO/CRC_HI are sent after the last payload byte.
- Undefined: CRC logic and states removed; STOP of the last byte goes directly to POST. Payload is expected to already contain its CRC.

Test Plan:
- div=3, pre=2, post=1, CRC_EN. Frame ASCII "123456789" (0x31..0x39, in_last on 0x39).
  - CRC bytes on tx are 0x37 then 0x4B.
  - tx_en high for exactly (2+110+1)*4 = 452 clocks; first start bit falls at 8 clocks after tx_en rises.
- div=0, pre=0, post=0, single byte 0xA5 with in_last, CRC_EN.
  - tx sequence 0,1,0,1,0,0,1,0,1,1 then the CRC characters; tx_en rises one cycle after the accept.
- Underrun: 2-byte frame, second byte withheld until after the first STOP.
  - underrun pulses once; no CRC sent; tx_en drops after post_len; in_ready stays low until IDLE.
- Backpressure: in_valid held high for a 4-byte frame.
  - in_ready low while the holding register is full; every byte is transmitted exactly once, in order.
- Reset asserted mid-DATA of byte 2.
  - tx=1, tx_en=0 asynchronously; after release, a new 1-byte frame starts with CRC init 0xFFFF and is correct.
- CDBUS_TX_CRC_EN undefined, same frame as scenario 1.
  - tx_en high (2+90+1)*4 = 372 clocks; last character on tx is 0x39.
